// File: rtl/prescaler_bank_if.sv
// Configuration and output bundle for prescaler_bank.
// Signalling: there is no valid/ready pair. wr_en is a single-cycle strobe
// that is always accepted on the rising edge where it is sampled high.
// Writes to channels that do not exist are dropped. en and sync are level
// inputs sampled on every edge. tick and clk_div are registered outputs.
interface prescaler_bank_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 32,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
);
    logic [CH-1:0]    en;
    logic             sync;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic             wr_mode;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    clk_div;

    modport master (
        output en, sync, wr_en, wr_ch, wr_div, wr_mode,
        input  tick, clk_div
    );

    modport slave (
        input  en, sync, wr_en, wr_ch, wr_div, wr_mode,
        output tick, clk_div
    );
endinterface

// File: rtl/prescaler_bank.sv
// Multi-channel programmable prescaler. Every channel has its own counter,
// an active divisor/mode pair and a shadow pair written through the shared
// configuration port. The shadow is copied to the active pair only at a
// period boundary, on sync, or while the channel is stopped (divisor 0).
// This keeps the divided outputs free of short glitch periods.
module prescaler_bank #(
    parameter int CH          = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 1000
) (
    input logic              src_clk,
    input logic              rst,
    prescaler_bank_if.slave  bus
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_a;
        logic [CNT_W-1:0] div_s;
        logic             mode_a;
        logic             mode_s;
        logic             tick_r;
        logic             clk_r;

        logic             wr_hit;
        logic [CNT_W-1:0] div_ld;
        logic             mode_ld;
        logic             wrap;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W:0]   half_cur;

        // Shadow bypass: a write in the same cycle as a load is what gets loaded.
        always_comb begin
            wr_hit   = bus.wr_en && (bus.wr_ch == CH_W'(i));
            div_ld   = wr_hit ? bus.wr_div  : div_s;
            mode_ld  = wr_hit ? bus.wr_mode : mode_s;
            // N-1 is only meaningful for N >= 1; div_a == 0 is masked out here.
            wrap     = (div_a != '0) && (cnt == (div_a - CNT_W'(1)));
            cnt_inc  = cnt + CNT_W'(1);
            // One extra bit so N = 2^CNT_W-1 does not overflow when rounding up.
            half_cur = ({1'b0, div_a} + (CNT_W+1)'(1)) >> 1;
        end

        // Per-channel counter, shadow/active registers and registered outputs.
        always_ff @(posedge src_clk) begin
            if (rst) begin
                cnt    <= '0;
                div_a  <= CNT_W'(DEFAULT_DIV);
                div_s  <= CNT_W'(DEFAULT_DIV);
                mode_a <= 1'b0;
                mode_s <= 1'b0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else begin
                div_s  <= div_ld;
                mode_s <= mode_ld;
                if (bus.sync) begin
                    // Re-phase: square channels restart in their high half.
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    div_a  <= div_ld;
                    mode_a <= mode_ld;
                    clk_r  <= mode_ld && (div_ld != '0);
                end else if (div_a == '0) begin
                    // Stopped channel keeps tracking the shadow every cycle.
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    clk_r  <= 1'b0;
                    div_a  <= div_ld;
                    mode_a <= mode_ld;
                end else if (bus.en[i]) begin
                    if (wrap) begin
                        // Period boundary: next count is 0, which is always in
                        // the high half of a square wave with N >= 1.
                        cnt    <= '0;
                        tick_r <= 1'b1;
                        div_a  <= div_ld;
                        mode_a <= mode_ld;
                        clk_r  <= mode_ld ? (div_ld != '0) : 1'b1;
                    end else begin
                        cnt    <= cnt_inc;
                        tick_r <= 1'b0;
                        clk_r  <= mode_a ? ({1'b0, cnt_inc} < half_cur) : 1'b0;
                    end
                end else begin
                    // Disabled: count and divided level freeze, no strobe.
                    tick_r <= 1'b0;
                end
            end
        end

        assign bus.tick[i]    = tick_r;
        assign bus.clk_div[i] = clk_r;
    end
endmodule

// File: tb/tb_prescaler_bank.sv
// Bench for prescaler_bank: directed scenarios with literal expectations plus
// a period-level reference model compared against the outputs every cycle.
module tb_prescaler_bank;
    localparam int CH          = 4;
    localparam int CNT_W       = 32;
    localparam int DEFAULT_DIV = 1000;
    localparam int CH_W        = 2;

    logic src_clk = 1'b0;
    logic rst;

    prescaler_bank_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

    prescaler_bank #(
        .CH(CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .src_clk (src_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    always #5 src_clk = ~src_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit model_live = 1'b0;
    logic [2*CH-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // pos = enabled cycles completed in the current period; a period ends
    // when pos reaches N. Square output is high while pos < ceil(N/2).
    int unsigned m_pos [CH];
    int unsigned m_n   [CH];
    int unsigned m_ns  [CH];
    bit          m_mode[CH];
    bit          m_ms  [CH];
    bit          m_tick[CH];
    bit          m_clk [CH];

    always @(posedge src_clk) begin
        logic [2*CH-1:0] e;
        int unsigned ns;
        bit ms;
        cyc++;
        for (int c = 0; c < CH; c++) begin
            ns = (bus.wr_en && int'(bus.wr_ch) == c) ? bus.wr_div  : m_ns[c];
            ms = (bus.wr_en && int'(bus.wr_ch) == c) ? bus.wr_mode : m_ms[c];
            if (rst) begin
                m_pos[c] = 0; m_n[c] = DEFAULT_DIV; m_mode[c] = 0;
                m_tick[c] = 0; m_clk[c] = 0;
                ns = DEFAULT_DIV; ms = 0;
            end else if (bus.sync) begin
                m_pos[c] = 0; m_n[c] = ns; m_mode[c] = ms;
                m_tick[c] = 0; m_clk[c] = ms && (ns >= 1);
            end else if (m_n[c] == 0) begin
                m_pos[c] = 0; m_n[c] = ns; m_mode[c] = ms;
                m_tick[c] = 0; m_clk[c] = 0;
            end else if (bus.en[c]) begin
                m_pos[c] = m_pos[c] + 1;
                if (m_pos[c] == m_n[c]) begin
                    m_pos[c] = 0; m_n[c] = ns; m_mode[c] = ms;
                    m_tick[c] = 1;
                    m_clk[c] = m_mode[c] ? (m_n[c] >= 1) : 1'b1;
                end else begin
                    m_tick[c] = 0;
                    m_clk[c] = m_mode[c] ? (m_pos[c] < (m_n[c] + 1) / 2) : 1'b0;
                end
            end else begin
                m_tick[c] = 0;
            end
            m_ns[c] = ns;
            m_ms[c] = ms;
        end
        for (int c = 0; c < CH; c++) begin
            e[c]      = m_tick[c];
            e[CH + c] = m_clk[c];
        end
        exp_q.push_back(e);
        model_live = 1'b1;
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge src_clk) begin
        logic [2*CH-1:0] e;
        if (model_live && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.clk_div, bus.tick} !== e) begin
                failures++;
                $display("FAIL model cyc=%0d clk_div/tick got %b_%b expected %b_%b",
                         cyc, bus.clk_div, bus.tick, e[2*CH-1:CH], e[CH-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge src_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic write(input int ch, input int div, input bit mode);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = CH_W'(ch);
        bus.wr_div  = CNT_W'(div);
        bus.wr_mode = mode;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bit pat[5];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        bus.en = '0; bus.sync = 1'b0; bus.wr_en = 1'b0;
        bus.wr_ch = '0; bus.wr_div = '0; bus.wr_mode = 1'b0;
        repeat (3) step();
        check("reset_tick", 32'(bus.tick), 32'h0);
        check("reset_clk", 32'(bus.clk_div), 32'h0);

        // Park ch2/ch3 stopped, start ch0 at N=4 pulse via write+sync.
        rst = 1'b0;
        write(2, 0, 0); step();
        write(3, 0, 0); step();
        write(0, 4, 0); bus.sync = 1'b1; bus.en = '1; step();
        bus.wr_en = 1'b0; bus.sync = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("n4_tick0", 32'(bus.tick[0]), 32'(k % 4 == 0));
            check("n4_clk0", 32'(bus.clk_div[0]), 32'(k % 4 == 0));
        end

        // ch1 N=5 square, then sync.
        write(1, 5, 1); step();
        bus.wr_en = 1'b0; bus.sync = 1'b1; step();
        bus.sync = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check("sq5_clk1", 32'(bus.clk_div[1]), 32'(pat[k % 5]));
            check("sq5_tick1", 32'(bus.tick[1]), 32'(k > 0 && k % 5 == 0));
            step();
        end

        // ch0 N=8, rewritten to N=3 while cnt=2: 8-cycle period then 3s.
        write(0, 8, 0); bus.sync = 1'b1; step();
        bus.wr_en = 1'b0; bus.sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("chg_tick0", 32'(bus.tick[0]), 32'(k == 8 || k == 11 || k == 14));
            check("chg_clk0", 32'(bus.clk_div[0]), 32'(k == 8 || k == 11 || k == 14));
            if (k == 2) write(0, 3, 0);
            if (k == 3) bus.wr_en = 1'b0;
        end

        // ch2 N=6 and ch3 N=3 started at different times, then sync aligns them.
        write(2, 6, 0); step();
        write(3, 3, 0); step();
        bus.wr_en = 1'b0;
        repeat (3) step();
        bus.sync = 1'b1; step();
        bus.sync = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("align_tick2", 32'(bus.tick[2]), 32'(k % 6 == 0));
            check("align_tick3", 32'(bus.tick[3]), 32'(k % 3 == 0));
        end

        // en[0] dropped for 3 cycles at N=4: that period measures 7.
        write(0, 4, 0); bus.sync = 1'b1; step();
        bus.wr_en = 1'b0; bus.sync = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("gate_tick0", 32'(bus.tick[0]), 32'(k == 4 || k == 11));
            check("gate_clk0", 32'(bus.clk_div[0]), 32'(k == 4 || k == 11));
            if (k == 5) bus.en[0] = 1'b0;
            if (k == 8) bus.en[0] = 1'b1;
        end

        // ch1 stopped by N=0, then restarted at N=2.
        write(1, 0, 0); step();
        bus.wr_en = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            check("stop_tick1", 32'(bus.tick[1]), 32'h0);
            check("stop_clk1", 32'(bus.clk_div[1]), 32'h0);
            step();
        end
        write(1, 2, 0); step();
        bus.wr_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("restart_tick1", 32'(bus.tick[1]), 32'(k % 2 == 0));
        end

        // Reset mid-operation with pending shadow writes.
        write(0, 7, 1); step();
        write(3, 9, 0); step();
        bus.wr_en = 1'b0; rst = 1'b1; step();
        check("rst_tick", 32'(bus.tick), 32'h0);
        check("rst_clk", 32'(bus.clk_div), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            check("dflt_tick", 32'(bus.tick), (k % DEFAULT_DIV == 0) ? 32'hF : 32'h0);
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prescaler_bank.md
# prescaler_bank

Multi-channel programmable prescaler: CH independent counters all driven from `src_clk`, each with a divisor and output mode that can be changed at run time. Each channel outputs a one-cycle `tick` strobe and a `clk_div` enable that is either a pulse or a near-50% square wave. It replaces the fixed single-divisor prescaler in the sample-rate and NCO timing path. A `sync` input re-phases all channels together.

## Interface
- `CH`, 4: number of channels.
- `CNT_W`, 32: counter and divisor width.
- `DEFAULT_DIV`, 1000: divisor loaded into every channel at reset.

Ports:
- `src_clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  CH  per-channel count enable.
- `sync`  in  1  restarts all channels at count 0 and applies pending divisors.
- `wr_en`  in  1  configuration write strobe.
- `wr_ch`  in  $clog2(CH) (min 1)  channel addressed by the write.
- `wr_div`  in  CNT_W  new divisor N.
- `wr_mode`  in  1  0 = pulse, 1 = square.
- `tick`  out  CH  one-cycle strobe at each period wrap.
- `clk_div`  out  CH  divided output, shape set by mode.

## Operation
- Per-channel state:
  - `cnt` (CNT_W bits).
  - Active divisor `div_a` and shadow divisor `div_s`.
  - Active mode `mode_a` and shadow mode `mode_s`.
- Write:
  - When `wr_en` is high, `div_s[wr_ch]` <= `wr_div` and `mode_s[wr_ch]` <= `wr_mode`.
  - A write to `wr_ch` >= CH is ignored.
- Shadow to active copy (glitch-free) happens on any of:
  - the channel's wrap;
  - `sync`;
  - any cycle in which `div_a` == 0.
- Count, per channel, when `en` is high and `div_a` = N >= 1:
  - If `cnt` == N-1: `cnt` <= 0, `tick` <= 1, load shadow.
  - Otherwise: `cnt` <= `cnt`+1, `tick` <= 0.
- Pulse mode: `clk_div` <= same value as `tick`.
- Square mode:
  - `clk_div` <= (`cnt_next` < H), where H = (N+1)>>1.
  - The output is high for ceil(N/2) cycles and low for floor(N/2) cycles.
  - N=1 gives a constant 1.
- N = 0: the channel is stopped.
  - `cnt` <= 0, `tick` <= 0, `clk_div` <= 0.
  - The shadow is copied every cycle, so a nonzero write takes effect on the next cycle.
- `en` low:
  - `cnt` and `clk_div` hold.
  - `tick` <= 0.
  - No shadow copy, except through `sync` or `div_a` == 0.
- `sync` (overrides counting for all channels, regardless of `en`):
  - `cnt` <= 0, `tick` <= 0, shadow copied.
  - `clk_div` <= 1 if the new mode is square and new N >= 1, else 0.
- Precedence per channel: `rst` > `sync` > `div_a`==0 > `en`.
- A write and a `sync` in the same cycle: the written value is stored in the shadow and is also the value that `sync` loads.
- A write in a channel's wrap cycle: the new value is used for the following period.
- Reset state:
  - `cnt`=0.
  - `div_a`=`div_s`=DEFAULT_DIV.
  - `mode_a`=`mode_s`=0.
  - `tick`=0, `clk_div`=0 on all channels.
- `rst` asserted mid-period discards pending shadow writes.
- Arithmetic:
  - All compares are unsigned CNT_W.
  - N-1 is computed only when N >= 1.
  - H is computed in CNT_W+1 bits so that N = 2^CNT_W-1 does not overflow.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- From reset release or `sync` with `en` high throughout: the first `tick` is high in the cycle after the Nth rising edge, then every N cycles.
- Period is exactly N enabled cycles. Disabled cycles stretch the period one-for-one.
- Divisor-change latency:
  - takes effect at the next wrap;
  - or on the cycle after `sync`;
  - or on the cycle after the write when `div_a`==0.
- Channels are mutually independent apart from `sync` and the shared write port.

## Test plan
- Reset, ch0 N=4, pulse mode, `en`=1:
  - `tick[0]` and `clk_div[0]` are high for 1 cycle of every 4.
  - The first high is on cycle 5 after reset release.
- ch1 written N=5, mode=1, then `sync`: `clk_div[1]` repeats the pattern 1,1,1,0,0; `tick[1]` fires once per 5 cycles.
- ch0 running at N=8: write N=3 at `cnt`=2.
  - The current period completes as 8 cycles.
  - Subsequent periods are 3 cycles.
  - No intermediate short pulse appears.
- ch2 N=6 and ch3 N=3 started at different times, then `sync`: after sync, every `tick[2]` coincides with every second `tick[3]`.
- `en[0]` dropped for 3 cycles mid-period at N=4:
  - `tick` stays low during the drop.
  - That period measures 7 cycles.
- Write N=0 to ch1: `clk_div[1]`=`tick[1]`=0 and stays so; writing N=2 restarts ch1 with its first tick 2 cycles later.
- Assert `rst` mid-operation after writes: all outputs are 0 on the next cycle, and the DEFAULT_DIV period resumes.
